// File: rtl/mul_sequencer.sv
// mul_sequencer: sits between the execute stage and the iterative 16x16 MAC
// multiplier. Runs one multiply-class request at a time, holds its operands
// stable at the multiplier, stalls the pipeline until the result is ready,
// and keeps a one-entry result cache so that an identical repeated request
// completes in its own cycle.
//
// Handshake: the execute stage raises req_i with op_i/rs1_i/rs2_i and keeps
// all of them steady while stall_o is high. ready_o pulses for exactly one
// cycle per delivered request, with result_o valid in that cycle only.
// stall_o and ready_o are never high together. flush_i withdraws the request
// in flight: the multiplier still finishes (it cannot abort), but nothing is
// delivered and the cache is left untouched.

package mul_sequencer_pkg;

    typedef enum logic [2:0] {
        NOP    = 3'd0,
        MUL    = 3'd1,
        MULH   = 3'd2,
        MULHSU = 3'd3,
        MULHU  = 3'd4
    } iType_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

endpackage

module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_i,
    input  iType_e      op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        ready_o,
    output logic [31:0] result_o,
    output logic [31:0] mul_first_operand_o,
    output logic [31:0] mul_second_operand_o,
    output iType_e      mul_operation_o,
    input  logic        mul_hold_i,
    input  logic [31:0] mul_result_i,
    output seq_state_e  state_o
);

    seq_state_e  state_q, state_d;

    iType_e      op_q;
    logic [31:0] rs1_q, rs2_q;

    logic        cache_valid_q;
    iType_e      cache_op_q;
    logic [31:0] cache_rs1_q, cache_rs2_q, cache_result_q;

    logic        cache_hit;
    logic        capture;
    logic        cache_load;

    assign state_o = state_q;

    // A hit needs the whole request to match the last delivered one.
    assign cache_hit = (CACHE_EN != 1'b0) && cache_valid_q
                    && (op_i == cache_op_q)
                    && (rs1_i == cache_rs1_q)
                    && (rs2_i == cache_rs2_q);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all outputs. The accept cycle drives the multiplier
    // straight from the inputs so it starts without a bubble; afterwards
    // only the latched registers reach it.
    always_comb begin
        state_d              = state_q;
        stall_o              = 1'b0;
        ready_o              = 1'b0;
        result_o             = 32'd0;
        mul_operation_o      = NOP;
        mul_first_operand_o  = 32'd0;
        mul_second_operand_o = 32'd0;
        capture              = 1'b0;
        cache_load           = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (cache_hit) begin
                        // A flushed hit is simply dropped.
                        if (!flush_i) begin
                            ready_o  = 1'b1;
                            result_o = cache_result_q;
                        end
                    end else begin
                        mul_operation_o      = op_i;
                        mul_first_operand_o  = rs1_i;
                        mul_second_operand_o = rs2_i;
                        capture              = 1'b1;
                        stall_o              = 1'b1;
                        state_d              = flush_i ? DRAIN : BUSY;
                    end
                end
            end

            BUSY: begin
                mul_operation_o      = op_q;
                mul_first_operand_o  = rs1_q;
                mul_second_operand_o = rs2_q;
                if (mul_hold_i) begin
                    stall_o = 1'b1;
                    if (flush_i) begin
                        state_d = DRAIN;
                    end
                end else begin
                    // Final multiplier step: deliver unless flushed now.
                    state_d = IDLE;
                    if (!flush_i) begin
                        ready_o    = 1'b1;
                        result_o   = mul_result_i;
                        cache_load = 1'b1;
                    end
                end
            end

            DRAIN: begin
                mul_operation_o      = op_q;
                mul_first_operand_o  = rs1_q;
                mul_second_operand_o = rs2_q;
                stall_o              = req_i;
                if (!mul_hold_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand registers, loaded only in the accept cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= NOP;
            rs1_q <= 32'd0;
            rs2_q <= 32'd0;
        end else if (capture) begin
            op_q  <= op_i;
            rs1_q <= rs1_i;
            rs2_q <= rs2_i;
        end
    end

    // One-entry result cache; survives flushes, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cache_valid_q  <= 1'b0;
            cache_op_q     <= NOP;
            cache_rs1_q    <= 32'd0;
            cache_rs2_q    <= 32'd0;
            cache_result_q <= 32'd0;
        end else if (cache_load) begin
            cache_valid_q  <= 1'b1;
            cache_op_q     <= op_q;
            cache_rs1_q    <= rs1_q;
            cache_rs2_q    <= rs2_q;
            cache_result_q <= mul_result_i;
        end
    end

endmodule
